// File: rtl/rrp_mult_arb.sv
// Round-robin arbiter and sequencer for one shared signed-digit multiplier.
// Products return through a credit-protected result FIFO, tagged with requester id.
module rrp_mult_arb #(
    parameter int RADIX      = 2,
    parameter int WIDTH      = 7,
    parameter int MULT_LAT   = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int D = $clog2(RADIX) + 1,
    localparam int N = D * WIDTH,
    localparam int P = D * (2 * WIDTH + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_x,
    input  logic [N-1:0] req0_y,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_x,
    input  logic [N-1:0] req1_y,
    output logic [N-1:0] mult_x,
    output logic [N-1:0] mult_y,
    input  logic [P-1:0] mult_p,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_id,
    output logic [P-1:0] res_p,
    output logic         busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(FIFO_DEPTH + MULT_LAT + 2) + 1;

    logic [MULT_LAT:0] tag_valid_reg, tag_valid_next;
    logic [MULT_LAT:0] tag_id_reg, tag_id_next;
    logic [P:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              rr_reg;
    logic [N-1:0]      mult_x_reg, mult_y_reg;

    logic [SW-1:0] inflight;
    logic          pop, push, can_issue, grant0, grant1, issue;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= MULT_LAT; i++) begin
            inflight = inflight + SW'(tag_valid_reg[i]);
        end
    end

    assign pop       = (count_reg != '0) & res_ready;
    assign push      = tag_valid_reg[MULT_LAT];
    // Every issued-but-unpopped product already owns a FIFO slot.
    assign can_issue = (SW'(count_reg) + inflight - SW'(pop)) < SW'(FIFO_DEPTH);

    // The pointer only matters when both requesters contend.
    assign grant0 = can_issue & req0_valid & (~req1_valid | ~rr_reg);
    assign grant1 = can_issue & req1_valid & (~req0_valid | rr_reg);
    assign issue  = grant0 | grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign tag_valid_next[0] = issue;
    assign tag_id_next[0]    = grant1;
    genvar gi;
    generate
        for (gi = 1; gi <= MULT_LAT; gi++) begin : g_tag
            assign tag_valid_next[gi] = tag_valid_reg[gi-1];
            assign tag_id_next[gi]    = tag_id_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid_reg <= '0;
            tag_id_reg    <= '0;
            mult_x_reg    <= '0;
            mult_y_reg    <= '0;
            rr_reg        <= 1'b0;
        end else begin
            tag_valid_reg <= tag_valid_next;
            tag_id_reg    <= tag_id_next;
            mult_x_reg    <= grant0 ? req0_x : (grant1 ? req1_x : '0);
            mult_y_reg    <= grant0 ? req0_y : (grant1 ? req1_y : '0);
            if (req0_valid & req1_valid & can_issue) begin
                rr_reg <= ~rr_reg;
            end
        end
    end

    assign mult_x = mult_x_reg;
    assign mult_y = mult_y_reg;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {tag_id_reg[MULT_LAT], mult_p};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign res_valid = (count_reg != '0);
    assign res_id    = fifo_mem[rd_ptr_reg][P];
    assign res_p     = fifo_mem[rd_ptr_reg][P-1:0];
    assign busy      = (inflight != '0) | (count_reg != '0);

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && (count_reg == CW'(FIFO_DEPTH))));
endmodule

// File: tb/tb_rrp_mult_arb.sv
// Randomized bench for rrp_mult_arb: behavioural multiplier plus a queue-based
// model of issue order, credit and round-robin choice.
module tb_rrp_mult_arb;
    localparam int WIDTH = 7, MULT_LAT = 1, FIFO_DEPTH = 4;
    localparam int D = 2, N = D * WIDTH, P = D * (2 * WIDTH + 1);

    logic clock = 0, reset = 1;
    logic r0v = 0, r1v = 0, res_ready = 0;
    logic [N-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic req0_ready, req1_ready, res_valid, res_id, busy;
    logic [N-1:0] mult_x, mult_y;
    logic [P-1:0] mult_p, res_p;
    logic [P-1:0] mpipe [MULT_LAT];

    int checks = 0, failures = 0, edges = 0;
    int dut_pops = 0, last_dut_p = 0;
    int grant_log[$];

    typedef struct { int id; int prod; int avail; } entry_t;
    entry_t q[$];
    logic m_rr = 0;

    rrp_mult_arb #(.RADIX(2), .WIDTH(WIDTH), .MULT_LAT(MULT_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(r0v), .req0_ready(req0_ready), .req0_x(x0), .req0_y(y0),
        .req1_valid(r1v), .req1_ready(req1_ready), .req1_x(x1), .req1_y(y1),
        .mult_x(mult_x), .mult_y(mult_y), .mult_p(mult_p),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_p(res_p),
        .busy(busy));

    always #5 clock = ~clock;
    always @(posedge clock) edges <= edges + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int dec(input logic [P-1:0] v, input int nd);
        int s = 0;
        logic signed [1:0] d;
        for (int i = 0; i < nd; i++) begin
            d = v[2*i +: 2];
            s += int'(d) * (1 << i);
        end
        return s;
    endfunction

    function automatic logic [P-1:0] enc(input int v);
        logic [P-1:0] r = '0;
        int mag = (v < 0) ? -v : v;
        for (int i = 0; i < 2 * WIDTH + 1; i++) begin
            if (mag[i]) r[2*i +: 2] = (v < 0) ? 2'b11 : 2'b01;
        end
        return r;
    endfunction

    function automatic logic [N-1:0] rand_op();
        logic [N-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            case ($urandom_range(0, 2))
                0:       r[2*i +: 2] = 2'b11;
                1:       r[2*i +: 2] = 2'b00;
                default: r[2*i +: 2] = 2'b01;
            endcase
        end
        return r;
    endfunction

    // Behavioural shared multiplier: registered, MULT_LAT clocks.
    always @(posedge clock) begin
        mpipe[0] <= enc(dec(P'(mult_x), WIDTH) * dec(P'(mult_y), WIDTH));
        for (int i = 1; i < MULT_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mult_p = mpipe[MULT_LAT-1];

    always @(negedge clock) begin
        logic ev, pop, can, e0, e1;
        if (reset) begin
            q.delete();
            m_rr = 0;
        end else begin
            ev = (q.size() > 0) && (q[0].avail <= edges);
            check("res_valid", int'(res_valid), int'(ev));
            if (ev && res_valid) begin
                check("res_id", int'(res_id), q[0].id);
                check("res_p", dec(res_p, 2 * WIDTH + 1), q[0].prod);
            end
            pop = ev & res_ready;
            can = (q.size() - int'(pop)) < FIFO_DEPTH;
            e0 = can & r0v & (!r1v | !m_rr);
            e1 = can & r1v & (!r0v | m_rr);
            check("req0_ready", int'(req0_ready), int'(e0));
            check("req1_ready", int'(req1_ready), int'(e1));
            check("busy", int'(busy), int'(q.size() != 0));
            if (res_valid && res_ready) begin
                last_dut_p = dec(res_p, 2 * WIDTH + 1);
                dut_pops++;
                $display("pop id=%0d p=%0d", res_id, last_dut_p);
            end
            if (pop) void'(q.pop_front());
            if (req0_ready && r0v) grant_log.push_back(0);
            if (req1_ready && r1v) grant_log.push_back(1);
            if (e0) q.push_back('{0, dec(P'(x0), WIDTH) * dec(P'(y0), WIDTH), edges + MULT_LAT + 2});
            if (e1) q.push_back('{1, dec(P'(x1), WIDTH) * dec(P'(y1), WIDTH), edges + MULT_LAT + 2});
            if (r0v && r1v && can) m_rr = !m_rr;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        r0v = 0; r1v = 0; res_ready = 1;
        while ((busy || res_valid) && n < 60) begin
            tick();
            n++;
        end
        check("drain_bound", int'(n < 60), 1);
        tick();
    endtask

    initial begin
        int pops_before;
        // 1: single request, 5*3
        reset = 1; tick(); tick(); reset = 0;
        res_ready = 1; r0v = 1; x0 = enc(5); y0 = enc(3);
        tick();
        r0v = 0;
        drain();
        check("t1_value", last_dut_p, 15);
        check("t1_pops", dut_pops, 1);

        // 2: both contending, alternation
        grant_log.delete();
        r0v = 1; r1v = 1; res_ready = 1;
        for (int i = 0; i < 20; i++) begin
            x0 = rand_op(); y0 = rand_op(); x1 = rand_op(); y1 = rand_op();
            tick();
        end
        drain();
        check("t2_grants", grant_log.size(), 20);
        for (int i = 0; i < grant_log.size(); i++) check("t2_alt", grant_log[i], i % 2);

        // 3: backpressure fills exactly FIFO_DEPTH credits
        grant_log.delete();
        res_ready = 0; r0v = 1;
        for (int i = 0; i < 10; i++) begin
            x0 = rand_op(); y0 = rand_op();
            tick();
        end
        check("t3_fill", grant_log.size(), FIFO_DEPTH);
        res_ready = 1; tick(); res_ready = 0;
        for (int i = 0; i < 4; i++) tick();
        check("t3_one_more", grant_log.size(), FIFO_DEPTH + 1);
        drain();

        // 4: extreme operands
        r0v = 1; x0 = enc(-127); y0 = enc(127);
        tick();
        drain();
        check("t4_value", last_dut_p, -16129);

        // 5: reset with 2 in flight and 2 queued
        grant_log.delete();
        res_ready = 0; r0v = 1;
        for (int i = 0; i < 4; i++) begin
            x0 = rand_op(); y0 = rand_op();
            tick();
        end
        check("t5_issued", grant_log.size(), 4);
        r0v = 0; reset = 1; tick(); reset = 0;
        pops_before = dut_pops;
        res_ready = 1;
        for (int i = 0; i < 6; i++) tick();
        check("t5_no_stale", dut_pops, pops_before);
        r0v = 1; x0 = enc(-9); y0 = enc(11);
        tick();
        drain();
        check("t5_new_value", last_dut_p, -99);
        check("t5_new_pops", dut_pops, pops_before + 1);

        // 6: pointer unchanged by single-requester service
        grant_log.delete();
        res_ready = 1; r1v = 1;
        for (int i = 0; i < 3; i++) begin
            x1 = rand_op(); y1 = rand_op();
            tick();
        end
        r0v = 1; x0 = rand_op(); y0 = rand_op();
        tick();
        drain();
        check("t6_len", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check("t6_g0", grant_log[0], 1);
            check("t6_g3", grant_log[3], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rrp_mult_arb.md
Name: rRp_mult_arb

Overview:
- Two-requester round-robin arbiter and sequencer for one shared rRp_mult instance (signed-digit radix-RADIX multiplier, registered product, fixed latency).
- Accepts operand pairs over valid/ready and drives the multiplier inputs.
- Tracks in-flight products with a tag pipeline and returns each product, tagged with its requester id, through a credit-protected result FIFO with valid/ready.

Parameters:
RADIX, 2, digit radix; digit set -(RADIX-1)..(RADIX-1)
WIDTH, 7, operand digits
MULT_LAT, 1, multiplier latency in clocks, >=1
FIFO_DEPTH, 4, result FIFO entries; must be >= MULT_LAT+2 for one-per-cycle throughput
(derived) D = $clog2(RADIX)+1 bits per digit; N = D*WIDTH; P = D*(2*WIDTH+1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
req0_valid  in  1  requester 0 has an operand pair
req0_ready  out  1  requester 0 granted this cycle
req0_x  in  N  requester 0 multiplicand, digit i at [i*D +: D], two's complement per digit
req0_y  in  N  requester 0 multiplier operand
req1_valid  in  1  requester 1 valid
req1_ready  out  1  requester 1 granted
req1_x  in  N  requester 1 multiplicand
req1_y  in  N  requester 1 multiplier operand
mult_x  out  N  registered operand to rRp_mult.x_in
mult_y  out  N  registered operand to rRp_mult.y_in
mult_p  in  P  rRp_mult.p_out
res_valid  out  1  FIFO head valid
res_ready  in  1  consumer accepts head
res_id  out  1  requester id of head product
res_p  out  P  head product digits, 2*WIDTH+1 digits
busy  out  1  any product in flight or queued

Behaviour:
- Reset (synchronous): mult_x=mult_y=0 (all digits zero), tag pipeline cleared, FIFO empty, res_valid=0, busy=0, RR pointer=0.
- Reset mid-operation discards all in-flight and queued products; nothing from before reset ever appears on res_*.
- Credit:
  - inflight = number of valid tag-pipeline stages (MULT_LAT+1 stages).
  - pop = res_valid & res_ready.
  - can_issue = (count + inflight - pop) < FIFO_DEPTH.
- Arbitration (combinational ready):
  - If can_issue=0, both readys are low.
  - If can_issue=1 and only one valid is high, that requester gets ready.
  - If both valids are high, the requester named by the RR pointer wins and the pointer toggles to the other requester on that handshake.
  - The pointer is unchanged when only one requester is served.
  - Exactly one ready is high at most.
  - Ready does not depend on the loser's valid.
- Issue: on a handshake edge, mult_x/mult_y load the winner's operands and tag stage 0 loads {valid=1, id}.
  - On non-issue edges, mult_x/mult_y load 0 and the stage 0 valid loads 0.
- Tag pipeline: shifts every cycle. Stage MULT_LAT+1 aligns with mult_p holding the product of the operands issued MULT_LAT+1 edges earlier.
  - When the aligned stage is valid, {id, mult_p} is written into the FIFO at that edge.
- Latency: handshake edge E -> FIFO write at edge E+MULT_LAT+1 -> res_valid high in the following cycle when the FIFO was empty (MULT_LAT+1 cycles after handshake).
- Ordering: results leave in issue order, not per-requester order.
- FIFO:
  - res_* is driven from the head register; it is stable while res_valid=1 and res_ready=0.
  - Simultaneous push and pop keeps count unchanged.
  - Credit rule guarantees no push when full; overflow is impossible. An assertion fires if it occurs.
  - Pop when empty is ignored.
- busy = (inflight != 0) | (count != 0).
- Arithmetic: none in the block; product digits pass through unmodified (redundant form, no normalisation).

Test Plan:
RADIX=2, WIDTH=7. Bench decodes value = sum(digit_i * 2^i).
1. Reset, then req0 only with x=5 (digits 1,0,1), y=3 (1,1). Expect req0_ready=1 the same cycle; res_valid 2 cycles after handshake; res_id=0; decoded res_p=15; busy drops the cycle after pop.
2. Both valid continuously with res_ready=1 and random operands. Expect grants alternating 0,1,0,1 starting at 0, one grant per cycle, each result matching x*y with the correct id in issue order.
3. res_ready=0 and req0 streaming. Expect exactly FIFO_DEPTH=4 handshakes, then readys low. Then res_ready=1 for one cycle: one pop, and exactly one further grant follows.
4. Operand x=-127 (all digits -1), y=127 (all digits 1). Expect decoded res_p=-16129 with no loss in the top digit.
5. Assert reset with 2 products in flight and 2 queued. Expect res_valid=0 the cycle after reset and no stale result afterwards. A new request yields its correct product.
6. req1 valid alone for 3 grants, then both valid. Expect req0 granted first, since the pointer is still 0.
